// File: rtl/dcfifo_pkg.sv
// Shared dual-clock FIFO helpers: gray decode, popcount and the default synchronizer depth.
// Pure functions and constants; no latency or backpressure of their own.
package dcfifo_pkg;

  localparam int DEFAULT_SYNC_STAGES = 2;

  // Upper bits zero-extended by the caller fold to 0, so one 32-bit form serves every width.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + 32'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/gray_to_binary.sv
// Registered gray-to-binary decode, one clock of latency.
// No flow control: a new code is accepted every cycle.
module gray_to_binary
  import dcfifo_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clock,
  input  logic             sclr_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clock) begin
    if (!sclr_n) begin
      dout <= '0;
    end else begin
      dout <= WIDTH'(gray2bin(32'(din)));
    end
  end

endmodule

// File: rtl/gray_ptr_receiver.sv
// Read-side receiver of a gray write pointer; wr_ptr_bin/used_words/empty follow wr_ptr_gray after SYNC_STAGES+1 edges.
// No backpressure: reads are taken while not empty, a read on empty pulses underflow and is dropped.
module gray_ptr_receiver
  import dcfifo_pkg::*;
#(
  parameter int WIDTH       = 5,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic             clock,
  input  logic             sclr_n,
  input  logic [WIDTH-1:0] wr_ptr_gray,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_ptr_bin,
  output logic [WIDTH-1:0] wr_ptr_bin,
  output logic [WIDTH-1:0] used_words,
  output logic             empty,
  output logic             underflow,
  output logic             gray_err
);

  (* async_reg = "true", dont_touch = "true" *) logic [WIDTH-1:0] sync [SYNC_STAGES];

  logic [WIDTH-1:0] sync_last;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] wr_bin_now;
  logic [WIDTH-1:0] rd_ptr_next;
  logic             rd_accept;

  always_ff @(posedge clock) begin
    if (!sclr_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync[i] <= '0;
      end
    end else begin
      sync[0] <= wr_ptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync[i] <= sync[i-1];
      end
    end
  end

  assign sync_last = sync[SYNC_STAGES-1];

  gray_to_binary #(
    .WIDTH (WIDTH)
  ) u_decode (
    .clock  (clock),
    .sclr_n (sclr_n),
    .din    (sync_last),
    .dout   (wr_ptr_bin)
  );

  // Occupancy and empty use the pre-register decode so they land on the same edge as wr_ptr_bin.
  always_comb begin
    wr_bin_now  = WIDTH'(gray2bin(32'(sync_last)));
    rd_accept   = rd_en & ~empty;
    rd_ptr_next = rd_ptr_bin + WIDTH'(rd_accept);
  end

  always_ff @(posedge clock) begin
    if (!sclr_n) begin
      rd_ptr_bin <= '0;
      used_words <= '0;
      empty      <= 1'b1;
      underflow  <= 1'b0;
      prev       <= '0;
      gray_err   <= 1'b0;
    end else begin
      rd_ptr_bin <= rd_ptr_next;
      used_words <= wr_bin_now - rd_ptr_next;
      empty      <= (wr_bin_now == rd_ptr_next);
      underflow  <= rd_en & empty;
      prev       <= sync_last;
      // Reported only; the decoded pointer is still taken as-is.
      gray_err   <= (popcount(32'(sync_last ^ prev)) > 32'd1);
    end
  end

endmodule

// File: tb/tb_gray_ptr_receiver.sv
// Bench for gray_ptr_receiver: vector table, corner sequences, and randomized run against a queue-based model.
module tb_gray_ptr_receiver;

  localparam int W = 5;
  localparam int S = 2;

  logic         clock = 1'b0;
  logic         sclr_n;
  logic [W-1:0] wr_ptr_gray;
  logic         rd_en;
  logic [W-1:0] rd_ptr_bin;
  logic [W-1:0] wr_ptr_bin;
  logic [W-1:0] used_words;
  logic         empty;
  logic         underflow;
  logic         gray_err;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  gray_ptr_receiver #(
    .WIDTH       (W),
    .SYNC_STAGES (S)
  ) dut (
    .clock       (clock),
    .sclr_n      (sclr_n),
    .wr_ptr_gray (wr_ptr_gray),
    .rd_en       (rd_en),
    .rd_ptr_bin  (rd_ptr_bin),
    .wr_ptr_bin  (wr_ptr_bin),
    .used_words  (used_words),
    .empty       (empty),
    .underflow   (underflow),
    .gray_err    (gray_err)
  );

  typedef struct {
    logic         rst_n;
    logic [W-1:0] gray;
    logic         rd;
    logic [W-1:0] e_rd;
    logic [W-1:0] e_wr;
    logic [W-1:0] e_used;
    logic         e_empty;
    logic         e_uf;
    logic         e_err;
  } vec_t;

  vec_t vecs [16];

  // Reference model: pointers as plain integers, synchronizer as a FIFO of sampled codes.
  logic [W-1:0] pipe [$];
  logic [W-1:0] m_rd, m_wr, m_used, m_prev;
  logic         m_empty, m_uf, m_err;

  function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [W-1:0] from_gray(input logic [W-1:0] g);
    logic [W-1:0] b;
    for (int k = 0; k < (1 << W); k++) begin
      b = W'(k);
      if (to_gray(b) == g) return b;
    end
    return '0;
  endfunction

  task automatic model_step();
    logic [W-1:0] d;
    if (!sclr_n) begin
      pipe.delete();
      for (int k = 0; k < S; k++) pipe.push_back('0);
      m_rd = '0; m_wr = '0; m_used = '0; m_prev = '0;
      m_empty = 1'b1; m_uf = 1'b0; m_err = 1'b0;
    end else begin
      d = pipe.pop_front();
      pipe.push_back(wr_ptr_gray);
      m_uf = rd_en && m_empty;
      if (rd_en && !m_empty) m_rd = m_rd + 1'b1;
      m_wr    = from_gray(d);
      m_used  = m_wr - m_rd;
      m_empty = (m_used == 0);
      m_err   = ($countones(d ^ m_prev) > 1);
      m_prev  = d;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [W-1:0] er, input logic [W-1:0] ew,
                           input logic [W-1:0] eu, input logic ee, input logic euf, input logic eg);
    check({tag, ".rd_ptr_bin"}, 32'(rd_ptr_bin), 32'(er));
    check({tag, ".wr_ptr_bin"}, 32'(wr_ptr_bin), 32'(ew));
    check({tag, ".used_words"}, 32'(used_words), 32'(eu));
    check({tag, ".empty"},      32'(empty),      32'(ee));
    check({tag, ".underflow"},  32'(underflow),  32'(euf));
    check({tag, ".gray_err"},   32'(gray_err),   32'(eg));
  endtask

  task automatic do_reset(input int n);
    sclr_n = 1'b0; rd_en = 1'b0; wr_ptr_gray = '0;
    repeat (n) tick();
    sclr_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] last_rd, wbin;
    int acc, ufs, budget;
    logic [2:0] err_exp;

    sclr_n = 1'b0; rd_en = 1'b0; wr_ptr_gray = '0;

    //            rst   gray      rd    rd    wr    used  emp   uf    err
    vecs[0]  = '{1'b0, 5'b10110, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 5'b10110, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 5'b00001, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 5'b00001, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 5'b00001, 1'b0, 5'd0, 5'd1, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 5'b00001, 1'b1, 5'd1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 5'b00001, 1'b1, 5'd1, 5'd1, 5'd0, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 5'b00011, 1'b0, 5'd1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 5'b00011, 1'b0, 5'd1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 5'b00011, 1'b0, 5'd1, 5'd2, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 5'b00101, 1'b0, 5'd1, 5'd2, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 5'b00101, 1'b0, 5'd1, 5'd2, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 5'b00101, 1'b0, 5'd1, 5'd6, 5'd5, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 5'b00101, 1'b0, 5'd1, 5'd6, 5'd5, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 5'b00101, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 5'b00101, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0};

    for (int v = 0; v < 16; v++) begin
      sclr_n = vecs[v].rst_n; wr_ptr_gray = vecs[v].gray; rd_en = vecs[v].rd;
      tick();
      check_all($sformatf("vec%0d", v), vecs[v].e_rd, vecs[v].e_wr, vecs[v].e_used,
                vecs[v].e_empty, vecs[v].e_uf, vecs[v].e_err);
    end

    // Two-bit gray jump: error pulse on the third edge only, decode still taken.
    do_reset(2);
    wr_ptr_gray = 5'b00011;
    err_exp = 3'b100;
    for (int e = 0; e < 4; e++) begin
      tick();
      check($sformatf("jump.gray_err.e%0d", e + 1), 32'(gray_err), (e < 3) ? 32'(err_exp[e]) : 32'd0);
      if (e == 2) begin
        check("jump.wr_ptr_bin", 32'(wr_ptr_bin), 32'd2);
        check("jump.used_words", 32'(used_words), 32'd2);
      end
    end

    // Fill to DEPTH, then drain with one extra read.
    do_reset(1);
    for (int b = 1; b <= 16; b++) begin
      wr_ptr_gray = to_gray(W'(b));
      tick();
    end
    repeat (3) tick();
    check("fill.wr_ptr_bin", 32'(wr_ptr_bin), 32'd16);
    check("fill.used_words", 32'(used_words), 32'd16);
    check("fill.empty",      32'(empty),      32'd0);
    rd_en = 1'b1; acc = 0; ufs = 0;
    for (int c = 0; c < 17; c++) begin
      last_rd = rd_ptr_bin;
      tick();
      if (rd_ptr_bin != last_rd) acc++;
      if (underflow) ufs++;
    end
    rd_en = 1'b0;
    check("drain.accepted",   32'(acc),        32'd16);
    check("drain.rd_ptr_bin", 32'(rd_ptr_bin), 32'd16);
    check("drain.empty",      32'(empty),      32'd1);
    check("drain.uf_pulses",  32'(ufs),        32'd1);

    // Wrap: read pointer to 31 while write pointer wraps to 1.
    for (int b = 17; b <= 31; b++) begin
      wr_ptr_gray = to_gray(W'(b));
      tick();
    end
    repeat (3) tick();
    rd_en = 1'b1; budget = 40;
    while (rd_ptr_bin != 5'd31 && budget > 0) begin
      tick();
      budget--;
    end
    rd_en = 1'b0;
    check("wrap.reach31", 32'(rd_ptr_bin), 32'd31);
    wr_ptr_gray = to_gray(5'd0); tick();
    wr_ptr_gray = to_gray(5'd1); tick();
    repeat (3) tick();
    check("wrap.rd_ptr_bin", 32'(rd_ptr_bin), 32'd31);
    check("wrap.wr_ptr_bin", 32'(wr_ptr_bin), 32'd1);
    check("wrap.used_words", 32'(used_words), 32'd2);
    rd_en = 1'b1;
    repeat (2) tick();
    rd_en = 1'b0;
    check("wrap.rd_after",    32'(rd_ptr_bin), 32'd1);
    check("wrap.empty_after", 32'(empty),      32'd1);
    check("wrap.used_after",  32'(used_words), 32'd0);

    // Randomized traffic with occasional glitches and resets.
    do_reset(2);
    wbin = '0;
    for (int c = 0; c < 1500; c++) begin
      int r;
      if ($urandom_range(0, 149) == 0) begin
        sclr_n = 1'b0;
      end else begin
        sclr_n = 1'b1;
        r = int'($urandom_range(0, 99));
        if (r < 3) wbin = W'($urandom_range(0, 31));
        else if (r < 45 && W'(wbin - m_rd) < 5'd16) wbin = wbin + 1'b1;
      end
      wr_ptr_gray = to_gray(wbin);
      rd_en = 1'($urandom_range(0, 1));
      tick();
      check_all($sformatf("rand%0d", c), m_rd, m_wr, m_used, m_empty, m_uf, m_err);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
